// File: rtl/rf_wb_queue_if.sv
// rtl/rf_wb_queue_if.sv - writeback queue producer/RF-side signal bundle
interface rf_wb_queue_if #(
  parameter int DEPTH = 8,
  parameter int AW    = 5,
  parameter int DW    = 32
);
  localparam int CW = $clog2(DEPTH + 1);

  logic              ld_v;
  logic [AW-1:0]     ld_addr;
  logic [DW-1:0]     ld_data;
  logic              in_v0;
  logic [AW-1:0]     in_addr0;
  logic [DW-1:0]     in_data0;
  logic              in_v1;
  logic [AW-1:0]     in_addr1;
  logic [DW-1:0]     in_data1;
  logic              in_rdy;
  logic              flush;
  logic              we0;
  logic [AW-1:0]     dst_addr0;
  logic [DW-1:0]     dst0;
  logic              we1;
  logic [AW-1:0]     dst_addr1;
  logic [DW-1:0]     dst1;
  logic [2**AW-1:0]  pend;
  logic [CW-1:0]     count;

  modport master (
    output ld_v, ld_addr, ld_data, in_v0, in_addr0, in_data0,
           in_v1, in_addr1, in_data1, flush,
    input  in_rdy, we0, dst_addr0, dst0, we1, dst_addr1, dst1, pend, count
  );

  modport slave (
    input  ld_v, ld_addr, ld_data, in_v0, in_addr0, in_data0,
           in_v1, in_addr1, in_data1, flush,
    output in_rdy, we0, dst_addr0, dst0, we1, dst_addr1, dst1, pend, count
  );
endinterface

// File: rtl/rf_wb_queue.sv
// rtl/rf_wb_queue.sv - in-order 3-in/2-out writeback FIFO for the dual-port register file
module rf_wb_queue #(
  parameter int DEPTH = 8,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input logic           clk,
  input logic           rst_n,
  rf_wb_queue_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [AW-1:0]    addr_mem [DEPTH];
  logic [DW-1:0]    data_mem [DEPTH];
  logic [PW-1:0]    rd_ptr, wr_ptr, head1;
  logic [PW-1:0]    idx_ld, idx0, idx1;
  logic [CW-1:0]    count_q;
  logic             rdy;
  logic             acc_ld, acc0, acc1;
  logic [1:0]       n_acc, n_pop;
  logic             we0_q, we1_q;
  logic [AW-1:0]    addr0_q, addr1_q;
  logic [DW-1:0]    data0_q, data1_q;
  logic [2**AW-1:0] pend_c;
  logic [PW-1:0]    off;

  assign rdy    = (count_q <= CW'(DEPTH - 3));
  assign acc_ld = bus.ld_v  && rdy && (bus.ld_addr  != '0);
  assign acc0   = bus.in_v0 && rdy && (bus.in_addr0 != '0);
  assign acc1   = bus.in_v1 && rdy && (bus.in_addr1 != '0);
  assign n_acc  = 2'(acc_ld) + 2'(acc0) + 2'(acc1);
  // Pop decision uses the pre-edge count, so same-edge arrivals are never drained.
  assign n_pop  = (count_q >= CW'(2)) ? 2'd2 : count_q[1:0];

  // Accepted results pack into consecutive slots in ld, slot0, slot1 order.
  assign idx_ld = wr_ptr;
  assign idx0   = wr_ptr + PW'(acc_ld);
  assign idx1   = wr_ptr + PW'(acc_ld) + PW'(acc0);
  assign head1  = rd_ptr + PW'(1);

  always_ff @(posedge clk) begin
    if (!bus.flush) begin
      if (acc_ld) begin
        addr_mem[idx_ld] <= bus.ld_addr;
        data_mem[idx_ld] <= bus.ld_data;
      end
      if (acc0) begin
        addr_mem[idx0] <= bus.in_addr0;
        data_mem[idx0] <= bus.in_data0;
      end
      if (acc1) begin
        addr_mem[idx1] <= bus.in_addr1;
        data_mem[idx1] <= bus.in_data1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
      we0_q   <= 1'b0;
      we1_q   <= 1'b0;
      addr0_q <= '0;
      addr1_q <= '0;
      data0_q <= '0;
      data1_q <= '0;
    end else if (bus.flush) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
      we0_q   <= 1'b0;
      we1_q   <= 1'b0;
    end else begin
      wr_ptr  <= wr_ptr + PW'(n_acc);
      rd_ptr  <= rd_ptr + PW'(n_pop);
      count_q <= count_q + CW'(n_acc) - CW'(n_pop);
      we0_q   <= (n_pop != 2'd0);
      we1_q   <= (n_pop == 2'd2);
      if (n_pop != 2'd0) begin
        addr0_q <= addr_mem[rd_ptr];
        data0_q <= data_mem[rd_ptr];
      end
      if (n_pop == 2'd2) begin
        addr1_q <= addr_mem[head1];
        data1_q <= data_mem[head1];
      end
    end
  end

  // An entry is live when its distance from the head is below the occupancy.
  always_comb begin
    pend_c = '0;
    off    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = PW'(i) - rd_ptr;
      if (CW'(off) < count_q) pend_c[addr_mem[i]] = 1'b1;
    end
  end

  assign bus.in_rdy    = rdy;
  assign bus.count     = count_q;
  assign bus.pend      = pend_c;
  assign bus.we0       = we0_q;
  assign bus.we1       = we1_q;
  assign bus.dst_addr0 = addr0_q;
  assign bus.dst_addr1 = addr1_q;
  assign bus.dst0      = data0_q;
  assign bus.dst1      = data1_q;
endmodule

// File: tb/tb_rf_wb_queue.sv
// tb/tb_rf_wb_queue.sv - directed bench for rf_wb_queue with a queue-based reference model
module tb_rf_wb_queue;
  localparam int DEPTH = 8;
  localparam int AW    = 5;
  localparam int DW    = 32;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   writes = 0;

  ent_t          q[$];
  logic          m_we0 = 1'b0, m_we1 = 1'b0;
  logic [AW-1:0] m_a0 = '0, m_a1 = '0;
  logic [DW-1:0] m_d0 = '0, m_d1 = '0;

  rf_wb_queue_if #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) bus ();

  rf_wb_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic lv, input logic [AW-1:0] la, input logic [DW-1:0] ldat,
                       input logic v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input logic v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    bus.ld_v = lv;  bus.ld_addr  = la; bus.ld_data  = ldat;
    bus.in_v0 = v0; bus.in_addr0 = a0; bus.in_data0 = d0;
    bus.in_v1 = v1; bus.in_addr1 = a1; bus.in_data1 = d1;
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  task automatic wait_empty();
    for (int i = 0; i < 50 && bus.count != 0; i++) @(negedge clk);
    chk("drain_to_empty", bus.count, 0);
    @(negedge clk);
  endtask

  // Reference model: program-ordered queue, up to two pops then up to three pushes per edge.
  initial begin : model_cmp
    int sz;
    ent_t e;
    logic [2**AW-1:0] ep;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        q.delete();
        m_we0 = 1'b0; m_we1 = 1'b0;
        m_a0 = '0; m_a1 = '0; m_d0 = '0; m_d1 = '0;
      end else if (bus.flush) begin
        q.delete();
        m_we0 = 1'b0; m_we1 = 1'b0;
      end else begin
        sz = q.size();
        m_we0 = (sz >= 1);
        m_we1 = (sz >= 2);
        if (m_we0) begin e = q.pop_front(); m_a0 = e.a; m_d0 = e.d; end
        if (m_we1) begin e = q.pop_front(); m_a1 = e.a; m_d1 = e.d; end
        if (sz <= DEPTH - 3) begin
          if (bus.ld_v  && bus.ld_addr  != 0) q.push_back({bus.ld_addr,  bus.ld_data});
          if (bus.in_v0 && bus.in_addr0 != 0) q.push_back({bus.in_addr0, bus.in_data0});
          if (bus.in_v1 && bus.in_addr1 != 0) q.push_back({bus.in_addr1, bus.in_data1});
        end
      end
      #1;
      if (rst_n) begin
        ep = '0;
        foreach (q[i]) ep[q[i].a] = 1'b1;
        chk("model_we0", bus.we0, m_we0);
        chk("model_we1", bus.we1, m_we1);
        chk("model_count", bus.count, q.size());
        chk("model_in_rdy", bus.in_rdy, q.size() <= DEPTH - 3);
        chk("model_pend", bus.pend, ep);
        if (m_we0) begin
          chk("model_addr0", bus.dst_addr0, m_a0);
          chk("model_data0", bus.dst0, m_d0);
        end
        if (m_we1) begin
          chk("model_addr1", bus.dst_addr1, m_a1);
          chk("model_data1", bus.dst1, m_d1);
        end
        writes += int'(bus.we0) + int'(bus.we1);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin : stim
    int   k;
    int   w0;
    logic acc;
    bus.flush = 1'b0;
    idle();

    // Reset held with inputs active
    drive(1'b1, 5'd9, 32'h9, 1'b1, 5'd10, 32'hA, 1'b1, 5'd11, 32'hB);
    repeat (3) @(negedge clk);
    chk("rst_we0", bus.we0, 0);
    chk("rst_we1", bus.we1, 0);
    chk("rst_count", bus.count, 0);
    chk("rst_in_rdy", bus.in_rdy, 1);
    chk("rst_pend", bus.pend, 0);
    chk("rst_addr0", bus.dst_addr0, 0);
    chk("rst_data0", bus.dst0, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("first_enq_count", bus.count, 3);
    chk("first_enq_pend", bus.pend, 32'h0000_0E00);
    idle();
    wait_empty();

    // Single slot-1 result
    drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd5, 32'hDEADBEEF);
    @(negedge clk);
    chk("s1_pend5", bus.pend[5], 1);
    chk("s1_count", bus.count, 1);
    idle();
    @(negedge clk);
    chk("s1_we0", bus.we0, 1);
    chk("s1_addr0", bus.dst_addr0, 5);
    chk("s1_data0", bus.dst0, 32'hDEADBEEF);
    chk("s1_we1", bus.we1, 0);
    chk("s1_count_after", bus.count, 0);
    chk("s1_pend_after", bus.pend, 0);
    @(negedge clk);

    // Same-address pair lands older on port 0, younger on port 1
    drive(1'b0, '0, '0, 1'b1, 5'd7, 32'd1, 1'b1, 5'd7, 32'd2);
    @(negedge clk);
    chk("pair_count", bus.count, 2);
    idle();
    @(negedge clk);
    chk("pair_we0", bus.we0, 1);
    chk("pair_addr0", bus.dst_addr0, 7);
    chk("pair_data0", bus.dst0, 1);
    chk("pair_we1", bus.we1, 1);
    chk("pair_addr1", bus.dst_addr1, 7);
    chk("pair_data1", bus.dst1, 2);
    @(negedge clk);

    // Fill with back-pressure; producer holds until accepted
    w0  = writes;
    k   = 0;
    acc = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (acc) begin
        if (k < 12) begin
          drive(1'b1, AW'((k*3+0) % 31 + 1), 32'hA000_0000 | (k << 8) | 0,
                1'b1, AW'((k*3+1) % 31 + 1), 32'hA000_0000 | (k << 8) | 1,
                1'b1, AW'((k*3+2) % 31 + 1), 32'hA000_0000 | (k << 8) | 2);
          k++;
        end else begin
          idle();
        end
      end
      acc = bus.in_rdy;
      @(negedge clk);
      if (cyc < 4) chk("fill_count", bus.count, 3 + cyc);
      if (cyc == 3) chk("fill_in_rdy_low", bus.in_rdy, 0);
      if (cyc == 4) chk("fill_hold_count", bus.count, 4);
    end
    idle();
    wait_empty();
    chk("fill_no_loss", writes - w0, 36);

    // Address-0 result is dropped
    drive(1'b0, '0, '0, 1'b1, 5'd0, 32'h1234, 1'b1, 5'd3, 32'h33);
    @(negedge clk);
    chk("r0_count", bus.count, 1);
    chk("r0_pend", bus.pend, 32'h8);
    idle();
    @(negedge clk);
    chk("r0_we0", bus.we0, 1);
    chk("r0_addr0", bus.dst_addr0, 3);
    chk("r0_data0", bus.dst0, 32'h33);
    chk("r0_we1", bus.we1, 0);
    @(negedge clk);

    // Flush at count 5 with all inputs valid
    drive(1'b1, 5'd20, 32'h20, 1'b1, 5'd21, 32'h21, 1'b1, 5'd22, 32'h22);
    @(negedge clk);
    drive(1'b1, 5'd23, 32'h23, 1'b1, 5'd24, 32'h24, 1'b1, 5'd25, 32'h25);
    @(negedge clk);
    drive(1'b1, 5'd26, 32'h26, 1'b1, 5'd27, 32'h27, 1'b1, 5'd28, 32'h28);
    @(negedge clk);
    chk("pre_flush_count", bus.count, 5);
    chk("pre_flush_in_rdy", bus.in_rdy, 1);
    drive(1'b1, 5'd29, 32'h29, 1'b1, 5'd30, 32'h30, 1'b1, 5'd31, 32'h31);
    bus.flush = 1'b1;
    @(negedge clk);
    chk("flush_count", bus.count, 0);
    chk("flush_we0", bus.we0, 0);
    chk("flush_we1", bus.we1, 0);
    chk("flush_pend", bus.pend, 0);
    bus.flush = 1'b0;
    idle();
    w0 = writes;
    repeat (3) @(negedge clk);
    chk("post_flush_count", bus.count, 0);
    chk("post_flush_no_writes", writes - w0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
